// File: rtl/hex_keypad_entry.sv
// hex_keypad_entry: scans a 4x4 active-low keypad, debounces, and shifts accepted keys into a 32-bit word
module hex_keypad_entry #(
  parameter int SCAN_DIV = 100000,
  parameter int DEBOUNCE_CYC = 500000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  input  logic        clear,
  output logic [3:0]  row,
  output logic [31:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic [3:0]  digit_count
);
  localparam int SW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam int DW = DEBOUNCE_CYC > 1 ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [SW-1:0] SLOT_END = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DB_END = DW'(DEBOUNCE_CYC - 1);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESS, RELEASE} state_t;
  state_t state;
  logic [3:0] col_m, col_s, pat, lows, code;
  logic [1:0] row_idx, col_idx;
  logic [SW-1:0] slot;
  logic [DW-1:0] cnt;
  logic one_low, idle;
  always_comb begin
    lows = ~col_s;
    idle = col_s == 4'hF;
    one_low = (lows != 4'd0) && ((lows & (lows - 4'd1)) == 4'd0);
    col_idx = !pat[0] ? 2'd0 : !pat[1] ? 2'd1 : !pat[2] ? 2'd2 : 2'd3;
    code = {row_idx, col_idx};
  end
  // Counters stop one short of the parameter: reaching DEBOUNCE_CYC matches means cnt == DEBOUNCE_CYC-1 on a match
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= SCAN;
      col_m <= 4'hF;
      col_s <= 4'hF;
      pat <= 4'hF;
      row_idx <= 2'd0;
      row <= 4'b1110;
      slot <= '0;
      cnt <= '0;
      value <= '0;
      key_code <= 4'd0;
      key_valid <= 1'b0;
      digit_count <= 4'd0;
    end else begin
      col_m <= col;
      col_s <= col_m;
      key_valid <= 1'b0;
      case (state)
        SCAN:
          if (slot != SLOT_END) slot <= slot + SW'(1);
          else begin
            slot <= '0;
            if (one_low) begin
              pat <= col_s;
              cnt <= '0;
              state <= DEBOUNCE;
            end else begin
              row_idx <= row_idx + 2'd1;
              row <= {row[2:0], row[3]};
            end
          end
        DEBOUNCE:
          if (col_s != pat) begin
            state <= SCAN;
            slot <= '0;
          end else if (cnt == DB_END) begin
            state <= PRESS;
            cnt <= '0;
            key_valid <= 1'b1;
            key_code <= code;
            value <= {value[27:0], code};
            digit_count <= digit_count == 4'd8 ? 4'd8 : digit_count + 4'd1;
          end else cnt <= cnt + DW'(1);
        PRESS: state <= RELEASE;
        RELEASE:
          if (!idle) cnt <= '0;
          else if (cnt == DB_END) begin
            state <= SCAN;
            slot <= '0;
            cnt <= '0;
          end else cnt <= cnt + DW'(1);
        default: state <= SCAN;
      endcase
      if (clear) begin
        value <= '0;
        digit_count <= 4'd0;
      end
    end
  end
endmodule
